// File: rtl/dm_pkg.sv
// Shared constants and helpers for the dm_sub_word data memory.
package dm_pkg;

  localparam logic [1:0] DMOP_WORD = 2'b00;
  localparam logic [1:0] DMOP_HALF = 2'b01;
  localparam logic [1:0] DMOP_BYTE = 2'b10;
  localparam logic [1:0] DMOP_RSVD = 2'b11;

  localparam int unsigned DM_DEPTH_WORDS = 3072;

  typedef logic [3:0] be_t;

  // Illegal size/alignment pair, independent of whether a load or store is happening.
  function automatic logic dm_misaligned(logic [1:0] dmop, logic [1:0] lane);
    return ((dmop == DMOP_WORD) && (lane != 2'b00)) ||
           ((dmop == DMOP_HALF) && lane[0]) ||
           (dmop == DMOP_RSVD);
  endfunction

endpackage

// File: rtl/dm_sub_word_if.sv
// Controller <-> data memory access interface (Memwrite/DMop bus).
interface dm_sub_word_if;
  logic [31:0] A;
  logic [31:0] WD;
  logic        Memwrite;
  logic [1:0]  DMop;
  logic [31:0] pc;
  logic [31:0] RD;
  logic        misalign;
  logic        err_sticky;

  modport master (
    output A, WD, Memwrite, DMop, pc,
    input  RD, misalign, err_sticky
  );

  modport slave (
    input  A, WD, Memwrite, DMop, pc,
    output RD, misalign, err_sticky
  );
endinterface

// File: rtl/dm_lane_merge.sv
// Byte-lane enable generation and store-data merge into an existing word.
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wd_i,
  input  logic [1:0]  dmop_i,
  input  logic [1:0]  lane_i,
  output be_t         be_o,
  output logic [31:0] merged_o
);

  logic [31:0] wd_rep;

  always_comb begin
    be_o   = 4'b0000;
    wd_rep = wd_i;
    unique case (dmop_i)
      DMOP_WORD: be_o = 4'b1111;
      DMOP_HALF: begin
        be_o   = lane_i[1] ? 4'b1100 : 4'b0011;
        wd_rep = {wd_i[15:0], wd_i[15:0]};
      end
      DMOP_BYTE: begin
        be_o   = 4'b0001 << lane_i;
        wd_rep = {4{wd_i[7:0]}};
      end
      default: be_o = 4'b0000;
    endcase
  end

  always_comb begin
    merged_o = old_word_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) merged_o[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_sub_word.sv
// Single-cycle MIPS data memory: sw/sh/sb byte-lane stores, sign-extended combinational loads.
// Optional store log enabled by defining DM_WRITE_LOG_EN.
module dm_sub_word
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int unsigned AW          = 12
) (
  input logic            clk,
  input logic            reset_n,
  dm_sub_word_if.slave   bus
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic        err_q, err_d;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word_addr;
  logic          oor;
  logic          misalign;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  be_t           be;
  logic          we;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [31:0]   rd;

  assign idx       = bus.A[AW+1:2];
  assign lane      = bus.A[1:0];
  // Full-width compare so address bits above AW also count as out of range.
  assign word_addr = {2'b00, bus.A[31:2]};
  assign oor       = word_addr >= 32'(DEPTH_WORDS);
  assign misalign  = dm_misaligned(bus.DMop, lane);
  assign old_word  = oor ? 32'h0 : mem_q[idx];

  dm_lane_merge u_lane_merge (
    .old_word_i (old_word),
    .wd_i       (bus.WD),
    .dmop_i     (bus.DMop),
    .lane_i     (lane),
    .be_o       (be),
    .merged_o   (merged)
  );

  assign we    = bus.Memwrite && !misalign && !oor && (be != 4'b0000);
  assign err_d = err_q | (bus.Memwrite & (misalign | oor));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 32'h0;
      err_q <= 1'b0;
    end else begin
      if (we) mem_q[idx] <= merged;
      err_q <= err_d;
    end
  end

  assign half_sel = lane[1] ? old_word[31:16] : old_word[15:0];
  assign byte_sel = old_word[8*lane +: 8];

  always_comb begin
    rd = old_word;
    if (oor) begin
      rd = 32'h0;
    end else if (!misalign) begin
      case (bus.DMop)
        DMOP_HALF: rd = {{16{half_sel[15]}}, half_sel};
        DMOP_BYTE: rd = {{24{byte_sel[7]}}, byte_sel};
        default:   rd = old_word;
      endcase
    end
  end

  assign bus.RD         = rd;
  assign bus.misalign   = misalign;
  assign bus.err_sticky = err_q;

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (reset_n && we) begin
      $display("%d@%h: *%h <= %h", $time, bus.pc, bus.A & ~32'd3, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

endmodule

// File: tb/tb_dm_sub_word.sv
// Randomized self-checking bench for dm_sub_word against a byte-addressed reference memory.
module tb_dm_sub_word;

  localparam int DEPTH = 3072;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] mem_b [4*DEPTH];
  logic       exp_err;

  dm_sub_word_if bus ();

  dm_sub_word u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic ref_oor(logic [31:0] a);
    return (a >> 2) >= 32'(DEPTH);
  endfunction

  function automatic logic ref_mis(logic [1:0] op, logic [31:0] a);
    case (op)
      2'd0:    return (a % 4) != 0;
      2'd1:    return (a % 2) != 0;
      2'd2:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(logic [1:0] op, logic [31:0] a);
    int ia;
    int b;
    logic [31:0] w;
    if (ref_oor(a)) return 32'h0;
    ia = int'(a);
    b  = ia - (ia % 4);
    w  = {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    if (ref_mis(op, a) || op == 2'd0) return w;
    if (op == 2'd1) return 32'($signed({mem_b[ia+1], mem_b[ia]}));
    return 32'($signed(mem_b[ia]));
  endfunction

  task automatic ref_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
    int n;
    if (ref_oor(a) || ref_mis(op, a)) begin
      exp_err = 1'b1;
      return;
    end
    n = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
    for (int k = 0; k < n; k++) mem_b[int'(a) + k] = wd[8*k +: 8];
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 4*DEPTH; i++) mem_b[i] = 8'h00;
    exp_err = 1'b0;
  endtask

  // One access per cycle: drive at negedge, check combinational outputs, commit at posedge.
  task automatic do_access(input logic we, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd_seen);
    @(negedge clk);
    bus.Memwrite = we;
    bus.DMop     = op;
    bus.A        = a;
    bus.WD       = wd;
    bus.pc       = 32'h0040_0000 + a;
    #1;
    rd_seen = bus.RD;
    check_eq("rd", bus.RD, ref_load(op, a));
    check_eq("misalign", 32'(bus.misalign), 32'(ref_mis(op, a)));
    @(posedge clk);
    #1;
    if (we) ref_store(op, a, wd);
    check_eq("err_sticky", 32'(bus.err_sticky), 32'(exp_err));
    bus.Memwrite = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] ra;

  initial begin
    bus.A = '0; bus.WD = '0; bus.Memwrite = 1'b0; bus.DMop = 2'd0; bus.pc = '0;
    ref_clear();
    #1;
    check_eq("reset_rd", bus.RD, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_access(1'b0, 2'd0, 32'h0, 32'h0, rd);         check_eq("lw_0", rd, 32'h0);
    do_access(1'b0, 2'd0, 32'h2FFC, 32'h0, rd);      check_eq("lw_2ffc", rd, 32'h0);
    check_eq("err_init", 32'(bus.err_sticky), 32'h0);

    do_access(1'b1, 2'd0, 32'h10, 32'h1234_5678, rd);
    do_access(1'b1, 2'd2, 32'h11, 32'h0000_00AB, rd);
    do_access(1'b1, 2'd1, 32'h12, 32'h0000_CDEF, rd);
    do_access(1'b0, 2'd0, 32'h10, 32'h0, rd);        check_eq("lw_10", rd, 32'hCDEF_AB78);
    do_access(1'b0, 2'd2, 32'h11, 32'h0, rd);        check_eq("lb_11", rd, 32'hFFFF_FFAB);
    do_access(1'b0, 2'd1, 32'h12, 32'h0, rd);        check_eq("lh_12", rd, 32'hFFFF_CDEF);
    do_access(1'b0, 2'd1, 32'h10, 32'h0, rd);        check_eq("lh_10", rd, 32'hFFFF_AB78);
    // Same-cycle read during a store shows the pre-write word.
    do_access(1'b1, 2'd0, 32'h10, 32'h0BAD_F00D, rd); check_eq("pre_write", rd, 32'hCDEF_AB78);
    do_access(1'b0, 2'd0, 32'h10, 32'h0, rd);        check_eq("post_write", rd, 32'h0BAD_F00D);

    do_access(1'b1, 2'd0, 32'h21, 32'hDEAD_BEEF, rd);
    check_eq("err_mis_sw", 32'(bus.err_sticky), 32'h1);
    do_access(1'b1, 2'd1, 32'h23, 32'hDEAD_BEEF, rd);
    do_access(1'b0, 2'd0, 32'h20, 32'h0, rd);        check_eq("lw_20", rd, 32'h0);
    check_eq("err_stays", 32'(bus.err_sticky), 32'h1);
    do_access(1'b1, 2'd0, 32'h3000, 32'hFFFF_FFFF, rd);
    do_access(1'b0, 2'd0, 32'h3000, 32'h0, rd);      check_eq("lw_3000", rd, 32'h0);

    // Mid-cycle reset with a store pending.
    @(posedge clk);
    #3;
    bus.Memwrite = 1'b1; bus.DMop = 2'd0; bus.A = 32'h10; bus.WD = 32'hFFFF_FFFF;
    reset_n = 1'b0;
    #1;
    check_eq("rst_err", 32'(bus.err_sticky), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.A = 32'h10 + 32'(i * 4);
      #1;
      check_eq("rst_rd", bus.RD, 32'h0);
    end
    bus.A = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.Memwrite = 1'b0;
    reset_n = 1'b1;
    ref_clear();
    do_access(1'b0, 2'd0, 32'h10, 32'h0, rd);        check_eq("rst_no_commit", rd, 32'h0);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = 32'h2FF0 + 32'($urandom_range(0, 15));
        1:       ra = $urandom();
        2:       ra = 32'h3000 + 32'($urandom_range(0, 15));
        default: ra = 32'($urandom_range(0, 63));
      endcase
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom(), rd);
      if (n == 300) begin
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        ref_clear();
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_sub_word.md
Name: dm_sub_word

Overview:
- Data memory for the single-cycle MIPS datapath.
- It is the responder for the controller's Memwrite/DMop interface.
- Performs word, halfword and byte stores (sw/sh/sb) using byte-lane merge into a word array.
- Returns sign-extended loads (lw/lh/lb) combinationally.
- Flags misaligned or out-of-range accesses, and keeps a sticky error register.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- AW, 12, word-index width; must satisfy 2^AW >= DEPTH_WORDS.

Ports:
- clk  in  1  system clock; all writes commit on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- A  in  32  byte address from the ALU result.
- WD  in  32  store data, i.e. the rt value; only the low 16 or 8 bits are used for sh/sb.
- Memwrite  in  1  store request.
- DMop  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
- pc  in  32  PC of the current instruction; used only by the optional log.
- RD  out  32  load data, sign-extended per DMop.
- misalign  out  1  combinational flag for the current access.
- err_sticky  out  1  registered error; stays set until reset.

Behaviour:
- Reset:
  - reset_n low asynchronously clears every array word to 0 and err_sticky to 0.
  - While reset_n is low, RD reads 0 and no write commits.
  - A reset asserted mid-cycle discards the pending write.
- Word index and byte lane:
  - Word index = A[AW+1:2]; byte lane = A[1:0].
- Out of range:
  - out_of_range = (A >> 2) >= DEPTH_WORDS; this includes any upper address bits beyond AW.
- Misaligned:
  - misalign = (DMop==00 && A[1:0]!=0) || (DMop==01 && A[0]) || DMop==11.
  - It is qualified by Memwrite OR a load being read.
  - The block cannot tell that a load is happening, so misalign is asserted whenever the address/DMop pair is illegal.
  - Consumers ignore misalign on non-memory instructions.
- Store (posedge clk, Memwrite=1, !misalign, !out_of_range):
  - Word: mem[idx] <= WD.
  - Half: byte enables 0011 if A[1]=0, else 1100; the targeted half is replaced with WD[15:0], the other half is unchanged.
  - Byte: enable bit A[1:0] set; lane A[1:0] is replaced with WD[7:0].
  - Read-modify-write happens within one cycle: the merge uses the current array contents.
- Illegal store (Memwrite=1 with misalign or out_of_range):
  - No array change.
  - err_sticky <= 1 at that edge.
- Load, zero latency (combinational from the array):
  - Word: RD = mem[idx].
  - Half: RD = sign-extend of the selected half (A[1] selects it).
  - Byte: RD = sign-extend of lane A[1:0].
  - Out of range reads 0.
  - Misaligned read returns the raw word, with misalign high.
- Store followed by load to the same word: the load in the next cycle sees the merged value. A same-cycle read shows the pre-write value.
- No back-pressure and no multi-cycle state; one access per cycle.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- When defined: each committed store prints "%d@%h: *%h <= %h" with $time, pc, word-aligned address (A & ~3), and the full merged 32-bit word, at the commit edge.
- Illegal stores print nothing.
- When undefined: no display statements are compiled; pc is unused.

Decomposition:
- Package dm_pkg:
  - DMOP_WORD=2'b00, DMOP_HALF=2'b01, DMOP_BYTE=2'b10, DMOP_RSVD=2'b11.
  - Default DEPTH_WORDS.
- Sub-module dm_lane_merge (combinational), shared by the store path and reused by the log:
  - Inputs: old word, WD, DMop, A[1:0].
  - Outputs: 4-bit byte enable and merged word.
- Load extraction and sign extension stay inline.

Test Plan:
- Reset then lw at 0x0 and 0x2FFC -> RD=0x00000000, err_sticky=0.
- sw 0x12345678 @0x10; sb WD=0xAB @0x11; sh WD=0xCDEF @0x12 -> lw @0x10 = 0xCDEFAB78.
- Same word: lb @0x11 -> 0xFFFFFFAB; lh @0x12 -> 0xFFFFCDEF; lh @0x10 -> 0xFFFFAB78.
- sw 0xDEADBEEF @0x21 (misaligned) -> misalign=1, word @0x20 unchanged, err_sticky=1 next edge and stays 1; sh @0x23 likewise.
- sw @0x3000 (out of range, DEPTH_WORDS=3072) -> no write, err_sticky=1, lw @0x3000 -> 0.
- Pull reset_n low between clock edges after writes -> immediate RD=0 for all addresses and err_sticky=0; a Memwrite held during reset commits nothing.
